up_run_ctrl: RTL
================

Name: up_run_ctrl

Overview:
- Run-control sequencer for the 4-bit uP core. Produces a single clock-enable, `core_en`, that gates every core flip-flop, including the phase toggle, PC, fetch registers, accumulator, flags and output register.
- Supports run, halt, multi-instruction step and a PC breakpoint, driven by pushbutton-style inputs.
- Halts only at instruction boundaries, so the core always stops with phase = 0 (fetch pending).

Parameters:
- PC_W, 12, width of pc and bp_addr.
- CNT_W, 8, width of step_count and the internal step counter.
- AUTO_RUN, 1, state after reset: 1 = RUN, 0 = HALT.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- run_btn  input  1  async level; rising edge = run command
- step_btn  input  1  async level; rising edge = step command
- halt_btn  input  1  async level; rising edge = halt command
- step_count  input  CNT_W  instructions per step command; 0 is treated as 1
- bp_en  input  1  breakpoint enable
- bp_addr  input  PC_W  breakpoint address
- pc  input  PC_W  core program counter
- phase  input  1  core phase: 0 = fetch cycle, 1 = execute cycle
- core_en  output  1  clock-enable to the core
- halted  output  1  1 when state = HALT (registered)
- bp_hit  output  1  sticky flag: last stop was caused by the breakpoint

Behaviour:
- **Input capture.** Each button passes through a 2-FF synchronizer plus a registered previous value.
  - cmd_x = sync2 & ~prev, a one-cycle pulse.
  - A button first sampled high at edge t0 gives a pulse in the cycle after t1; its effect is registered at t2.
  - Command priority: halt > step > run.
- **States.** HALT, RUN, STEP.
  - active = (state != HALT).
- **Enable equation.** stop_now = phase==0 & (cmd_halt | halt_pend | bp_match | step_done).
  - bp_match = bp_en & pc==bp_addr & ~bp_skip.
  - core_en = active & ~stop_now. This is combinational from pc/phase; it is the only combinational output.
- **Stop rule.** The execute cycle (phase 1) always completes. Any stop takes effect in a phase-0 cycle, with core_en held 0 in that cycle.
  - cmd_halt or halt_pend in phase 1 sets halt_pend; the core stops at the next phase 0.
- **HALT state.**
  - core_en = 0.
  - cmd_step → STEP, with remaining = max(step_count, 1).
  - cmd_run → RUN.
  - Either exit clears bp_hit and halt_pend and sets bp_skip.
  - cmd_halt has no effect.
- **RUN state.**
  - stop_now → HALT. bp_hit <= bp_match & ~(cmd_halt | halt_pend).
  - cmd_run and cmd_step are ignored.
- **STEP state.**
  - On every completed execute cycle (phase==1 & core_en): remaining <= remaining - 1.
  - step_done = (remaining == 0).
  - stop_now → HALT, with the same bp_hit rule as RUN.
  - cmd_run → RUN, keeping remaining unchanged.
  - cmd_step is ignored.
- **bp_skip.** Set on leaving HALT; cleared at the first completed execute cycle. This lets a resume from a breakpoint execute the breakpointed instruction once.
- **Reset** (asynchronous, any time, including mid-instruction):
  - state = RUN if AUTO_RUN, else HALT.
  - halted = ~AUTO_RUN.
  - bp_hit = 0, halt_pend = 0, bp_skip = 1, remaining = 0, all synchronizer/prev FFs = 0.
  - core_en then follows the enable equation: 1 in RUN with phase 0 unless bp_match, 0 in HALT.
- **Counter.** remaining is CNT_W bits and never wraps below 0. The decrement is inhibited when remaining == 0.
- **Boundary conditions:**
  - bp_en with bp_addr == pc at reset: bp_skip = 1, so no stop on the first instruction.
  - Breakpoint and step_done in the same cycle: stop; bp_hit = 1.
  - Button held high: one command only; it must be released and re-pressed.

Test Plan:
- AUTO_RUN=1, reset released → core_en=1 continuously; pc advances one instruction per 2 clk; halted=0.
- In RUN, pulse halt_btn during phase 1 → the execute cycle completes; the next phase-0 cycle has core_en=0; halted=1 one edge later; bp_hit=0; pc is frozen.
- From HALT, step_count=3, press step_btn → core_en high for exactly 6 clk cycles, then HALT; pc advanced by exactly 3 non-jump instructions. Repeat with step_count=0 → exactly 2 enabled cycles.
- bp_en=1, bp_addr=0x005, RUN from pc=0 → halts with pc=0x005, phase=0, bp_hit=1. Press run_btn → bp_hit=0; instruction at 0x005 executes; no re-stop at 0x005 until pc revisits it.
- In HALT, press step_btn and run_btn in the same cycle → STEP with the programmed count (step wins). In STEP, press run_btn mid-step → RUN continues with no halt.
- Assert rst_n=0 in the middle of STEP phase 1 → state, halted, bp_hit and counter take their reset values immediately without a clock; after release, behaviour matches the first scenario.

Source files
------------

// File: rtl/up_run_ctrl.sv
// ---------------------------------------------------------------------------
// up_run_ctrl - run-control sequencer for the 4-bit uP core.
//
// Generates core_en, the single clock-enable that gates every core flop.
// Supports run, halt, multi-instruction step and a PC breakpoint. Stops
// only at instruction boundaries, so the core is always left with
// phase = 0 (fetch pending).
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   run_btn     async level, rising edge = run command
//   step_btn    async level, rising edge = step command
//   halt_btn    async level, rising edge = halt command
//   step_count  instructions per step command (0 behaves as 1)
//   bp_en       breakpoint enable
//   bp_addr     breakpoint address
//   pc          core program counter
//   phase       core phase: 0 = fetch cycle, 1 = execute cycle
//   core_en     clock-enable to the core (combinational from pc/phase)
//   halted      registered, 1 while in HALT
//   bp_hit      sticky, last stop was caused by the breakpoint
// ---------------------------------------------------------------------------
module up_run_ctrl #(
  parameter int PC_W     = 12,
  parameter int CNT_W    = 8,
  parameter bit AUTO_RUN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_btn,
  input  logic             step_btn,
  input  logic             halt_btn,
  input  logic [CNT_W-1:0] step_count,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  input  logic             phase,
  output logic             core_en,
  output logic             halted,
  output logic             bp_hit
);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_e;

  localparam state_e            RST_STATE = AUTO_RUN ? ST_RUN : ST_HALT;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  // Button order in the vectors below: {halt, step, run}
  logic [2:0]       sync1_q, sync2_q, prev_q;
  logic [2:0]       cmd;
  logic             cmd_halt, cmd_step, cmd_run;

  state_e           state_q, state_d;
  logic             halted_q;
  logic             bp_hit_q, bp_hit_d;
  logic             halt_pend_q, halt_pend_d;
  logic             bp_skip_q, bp_skip_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;

  logic             active, bp_match, step_done, halt_req, stop_now, exec_done;

  // Two-flop synchronizer plus previous value for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= {halt_btn, step_btn, run_btn};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign cmd      = sync2_q & ~prev_q;
  assign cmd_halt = cmd[2];
  assign cmd_step = cmd[1];
  assign cmd_run  = cmd[0];

  // Enable equation: stops are only ever taken in a fetch (phase 0) cycle,
  // so an execute cycle that has started always completes.
  assign active    = (state_q != ST_HALT);
  assign bp_match  = bp_en & (pc == bp_addr) & ~bp_skip_q;
  assign step_done = (state_q == ST_STEP) & (remaining_q == '0);
  assign halt_req  = cmd_halt | halt_pend_q;
  assign stop_now  = ~phase & (halt_req | bp_match | step_done);
  assign core_en   = active & ~stop_now;
  assign exec_done = phase & core_en;

  always_comb begin
    state_d     = state_q;
    bp_hit_d    = bp_hit_q;
    halt_pend_d = halt_pend_q;
    bp_skip_d   = bp_skip_q;
    remaining_d = remaining_q;

    // bp_skip lets a resume execute the breakpointed instruction once
    if (exec_done) bp_skip_d = 1'b0;

    case (state_q)
      ST_HALT: begin
        // Halt outranks step/run; in HALT it simply swallows them
        if (!cmd_halt && (cmd_step || cmd_run)) begin
          bp_hit_d    = 1'b0;
          halt_pend_d = 1'b0;
          bp_skip_d   = 1'b1;
          if (cmd_step) begin
            state_d     = ST_STEP;
            remaining_d = (step_count == '0) ? CNT_ONE : step_count;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN, ST_STEP: begin
        if (stop_now) begin
          state_d  = ST_HALT;
          bp_hit_d = bp_match & ~halt_req;
        end else begin
          // A halt seen during execute is remembered until the next fetch
          if (phase && halt_req) halt_pend_d = 1'b1;
          if (state_q == ST_STEP) begin
            if (exec_done && (remaining_q != '0)) remaining_d = remaining_q - CNT_ONE;
            if (cmd_run && !cmd_halt) state_d = ST_RUN;
          end
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST_STATE;
      halted_q    <= (RST_STATE == ST_HALT);
      bp_hit_q    <= 1'b0;
      halt_pend_q <= 1'b0;
      bp_skip_q   <= 1'b1;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      halted_q    <= (state_d == ST_HALT);
      bp_hit_q    <= bp_hit_d;
      halt_pend_q <= halt_pend_d;
      bp_skip_q   <= bp_skip_d;
      remaining_q <= remaining_d;
    end
  end

  assign halted = halted_q;
  assign bp_hit = bp_hit_q;

endmodule
